// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with burst line refill for the fetch stage.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  input  logic        inv,
  output logic [31:0] instrF,
  output logic        icache_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tagMem [LINES];
  logic [31:0]       dataMem [LINES*WORDS];
  logic [OW-1:0]     beat;
  logic [TW+IW-1:0]  missLine;

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW-1:0] missIdx;
  logic [TW-1:0] missTag;
  logic          hit;
  logic          lastBeat;
  logic          unusedPc;

  assign off      = pcF[2+:OW];
  assign idx      = pcF[2+OW+:IW];
  assign tag      = pcF[31-:TW];
  assign unusedPc = ^pcF[1:0];
  assign missIdx  = missLine[IW-1:0];
  assign missTag  = missLine[IW+:TW];
  assign lastBeat = beat == OW'(WORDS-1);

  assign hit = (state == IDLE) && valid[idx]
             && (tagMem[idx] == tag);
  assign icache_stall = (state != IDLE)
                      | ((state == IDLE) & !hit);
  // Zero on a miss so a flushed decode sees a NOP.
  assign instrF = hit ? dataMem[{idx, off}] : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      valid    <= '0;
      beat     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      missLine <= '0;
    end else begin
      if (inv) valid <= '0;
      unique case (state)
        IDLE: begin
          if (!hit) begin
            missLine <= {tag, idx};
            beat     <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {tag, idx, {(OW+2){1'b0}}};
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            beat     <= beat + OW'(1);
            mem_addr <= mem_addr + 32'd4;
            // Late set overrides a coincident inv clear.
            if (lastBeat) begin
              valid[missIdx] <= 1'b1;
              mem_req        <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) begin
      dataMem[{missIdx, beat}] <= mem_rdata;
      if (lastBeat) tagMem[missIdx] <= missTag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCnt;
  logic [31:0] missCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hitCnt  <= '0;
      missCnt <= '0;
    end else begin
      if (hit) hitCnt <= hitCnt + 32'd1;
      if (state == IDLE && !hit) missCnt <= missCnt + 32'd1;
    end
  end

  assign hit_count  = hitCnt;
  assign miss_count = missCnt;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed scenarios then random fetches
// against a line-level valid/tag model and a wait-state memory.
module tb_icache_fetch;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pcF = 32'h40;
  logic        inv = 1'b0;
  logic [31:0] instrF;
  logic        icache_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad = 0;
  int waitCfg = 0;
  int waitCnt = 0;
  bit mv [LINES];
  int unsigned mt [LINES];
  int hitsM = 0;
  int missM = 0;

  icache_fetch #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .pcF(pcF), .inv(inv),
    .instrF(instrF), .icache_stall(icache_stall),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ PAT;
  assign mem_ready = mem_req && (waitCnt >= waitCfg);

  always_ff @(posedge clk) begin
    if (!mem_req || mem_ready) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic clearModel();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  // invBeat: -1 pulses with the fetch, >=0 at that refill beat.
  // rstBeat: >=0 asserts reset at that refill beat.
  task automatic fetch(input logic [31:0] pc,
                       input int invBeat,
                       input int rstBeat);
    int unsigned line, idx, tg;
    bit hitE, invHit;
    int stalls, beats, expStall;
    logic [31:0] base, want;
    line = pc / (4 * WORDS);
    idx  = line % LINES;
    tg   = line / LINES;
    base = line * 4 * WORDS;
    want = {pc[31:2], 2'b00} ^ PAT;
    hitE = mv[idx] && (mt[idx] == tg);
    expStall = hitE ? 0 : 1 + WORDS * (waitCfg + 1);
    invHit = 1'b0;
    stalls = 0;
    beats = 0;
    pcF = pc;
    if (invBeat == -1) begin
      inv = 1'b1;
      invHit = 1'b1;
    end
    #1;
    forever begin
      if (!icache_stall) break;
      stalls++;
      if (stalls > 400) begin
        total++;
        bad++;
        $error("FAIL timeout got=%0d exp=%0d", stalls, expStall);
        inv = 1'b0;
        return;
      end
      if (mem_req) begin
        chk("memAddr", mem_addr, base + 4 * beats);
        if (beats == rstBeat) begin
          reset = 1'b0;
          #1;
          chk("rstReq", {31'b0, mem_req}, 32'd0);
          chk("rstStall", {31'b0, icache_stall}, 32'd1);
          chk("rstInstr", instrF, 32'd0);
          @(negedge clk);
          @(negedge clk);
          reset = 1'b1;
          inv = 1'b0;
          clearModel();
          hitsM = 0;
          missM = 0;
          return;
        end
        if (beats == invBeat && !invHit) begin
          inv = 1'b1;
          invHit = 1'b1;
        end
        if (mem_ready) beats++;
      end
      @(negedge clk);
      inv = 1'b0;
      #1;
    end
    chk("stallCycles", stalls, expStall);
    chk("beats", beats, hitE ? 0 : WORDS);
    chk("instr", instrF, want);
    if (!hitE) missM++;
`ifdef ICACHE_STATS_EN
    chk("hitCount", hit_count, hitsM);
    chk("missCount", miss_count, missM);
`else
    chk("hitCount", hit_count, 32'd0);
    chk("missCount", miss_count, 32'd0);
`endif
    hitsM++;
    if (invHit) clearModel();
    if (!hitE) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    @(negedge clk);
    inv = 1'b0;
  endtask

  initial begin
    clearModel();
    #2;
    chk("resetStall", {31'b0, icache_stall}, 32'd1);
    chk("resetInstr", instrF, 32'd0);
    chk("resetReq", {31'b0, mem_req}, 32'd0);
    chk("resetAddr", mem_addr, 32'd0);
    chk("resetHits", hit_count, 32'd0);
    chk("resetMiss", miss_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    fetch(32'h40, -2, -2);
    fetch(32'h44, -2, -2);
    fetch(32'h48, -2, -2);
    fetch(32'h4C, -2, -2);

    fetch(32'h440, -2, -2);
    fetch(32'h40, -2, -2);

    waitCfg = 2;
    fetch(32'h104, -2, -2);
    waitCfg = 0;

    fetch(32'h80, 2, -2);
    fetch(32'h84, -2, -2);
    fetch(32'h40, -2, -2);

    fetch(32'hC8, 3, -2);
    fetch(32'hC0, -2, -2);
    fetch(32'h1C0, -1, -2);
    fetch(32'h1C4, -2, -2);

    fetch(32'h200, -2, 1);
    fetch(32'h40, -2, -2);
    fetch(32'h4C, -2, -2);

    for (int n = 0; n < 150; n++) begin
      int ib, r;
      logic [31:0] pc;
      pc = ($urandom_range(0, 2) << 8)
         | ($urandom_range(0, 3) << 4)
         | ($urandom_range(0, 3) << 2);
      waitCfg = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      ib = (r == 0) ? -1
         : (r == 1) ? $urandom_range(0, WORDS - 1) : -2;
      fetch(pc, ib, -2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
Direct-mapped instruction cache between the pipeline's fetch stage and a slow, word-wide instruction memory. It takes the fetch PC and returns the instruction word in the same cycle on a hit. On a miss it asserts a stall, which the hazard unit ORs into stallF/stallD. It then refills one full line with a registered burst-read state machine. It replaces the ideal combinational instruction memory that drives instrF today.

Parameters:
LINES, 16, number of cache lines; power of two, at least 2.
WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset; reset asserted when 0.
pcF  in  32  fetch byte address; bits [1:0] ignored.
inv  in  1  one-cycle pulse; invalidate entire cache.
instrF  out  32  instruction at pcF; valid when icache_stall=0.
icache_stall  out  1  fetch must hold; combinational.
mem_req  out  1  read request to instruction memory; registered.
mem_addr  out  32  word-aligned byte address of current beat; registered.
mem_ready  in  1  memory accepts the beat; mem_rdata valid this cycle.
mem_rdata  in  32  read data.
hit_count  out  32  hit counter (see Optional Feature).
miss_count  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split (word address pcF[31:2]):
  - offset = low log2(WORDS) bits.
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Storage:
  - valid[LINES] and tag[LINES] in flops.
  - data[LINES*WORDS] x 32, synchronous write, asynchronous read.
- Hit definition: state==IDLE, valid[index]=1 and tag[index]==pcF tag.
- icache_stall = (state!=IDLE) | (state==IDLE & !hit).
- instrF:
  - Equals data[index,offset] on a hit.
  - Otherwise 32'h0, so a bubble-safe NOP reaches a flushed decode register.
- FSM states IDLE and REFILL:
  - IDLE, miss: latch miss_base = {pcF tag, pcF index, zero offset}. Set beat=0, mem_req=1, mem_addr={miss_base,2'b00}. Go to REFILL.
  - REFILL, mem_ready=1: write mem_rdata into data[miss index, beat]. Increment beat and advance mem_addr by 4.
  - REFILL, beat==WORDS-1 with mem_ready=1: set valid[miss index]=1 and tag[miss index]=miss tag. Drop mem_req. Go to IDLE.
  - REFILL, mem_ready=0: hold mem_req, mem_addr and beat.
- Miss penalty with zero-wait memory is WORDS+1 stalled cycles. The instruction is delivered as a hit in the following cycle.
- pcF is required stable while stalled. If pcF changes during REFILL anyway, the refill completes for the latched miss_base. The new pcF is then looked up in IDLE.
- Invalidate:
  - inv=1 clears all valid bits on the next edge.
  - inv in IDLE during a miss cycle: clear valid bits and still start the refill.
  - inv during REFILL: the refill continues, and the refilled line is marked valid at completion, including when inv coincides with the final beat.
- Replacement: the refill overwrites the indexed line unconditionally. There is no dirty state.
- Reset (reset=0):
  - All valid bits, state=IDLE, beat=0, mem_req=0, mem_addr=0, counters=0.
  - Data and tag arrays are not reset.
  - While reset is asserted, icache_stall=1 and instrF=0, because every line is invalid.
- Reset asserted mid-refill aborts immediately. The partially written line stays invalid and mem_req drops asynchronously.

Optional Feature:
Macro ICACHE_STATS_EN.
- Defined:
  - hit_count increments once per clock in which state==IDLE and hit=1.
  - miss_count increments once per IDLE-to-REFILL transition.
  - Both counters are 32-bit, wrap from 32'hFFFFFFFF to 0, are cleared by reset, and are not cleared by inv.
- Undefined: hit_count and miss_count are tied to 32'h0, and no counter flops are synthesized.

Test Plan:
1. Cold miss, LINES=16, WORDS=4, zero-wait memory. Drive pcF=0x00000040, memory word at address A = A^0xA5A5A5A5.
   - Required: icache_stall=1 for 5 cycles.
   - Required: mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
   - Required: cycle 6 gives stall=0 and instrF=0xA5A5A5E5.
2. After test 1, step pcF 0x44, 0x48, 0x4C.
   - Required: stall=0 every cycle and instrF equal to the matching pattern.
   - Required with ICACHE_STATS_EN: hit_count=4 and miss_count=1.
3. Conflict: pcF=0x00000440, same index as 0x40 with a different tag.
   - Required: miss and refill 0x440..0x44C.
   - Required: returning to pcF=0x40 misses again.
4. Wait states: mem_ready=0 for 2 cycles before each beat.
   - Required: mem_addr held across waits.
   - Required: stall for 13 cycles, then the correct instrF.
5. inv pulse during REFILL beat 2 on pcF=0x80.
   - Required: line 0x80 ends valid with hit on the next IDLE cycle.
   - Required: the previously cached line 0x40 misses afterward.
6. Reset (reset=0) asserted at REFILL beat 1.
   - Required: mem_req=0 at once.
   - Required: after release, pcF=0x40 misses and refills fully.
